// File: rtl/voltmeter_pkg.sv
// Shared types and default widths for the ADC scan averager.
package voltmeter_pkg;

    localparam int unsigned DEF_DATA_W = 12;
    localparam int unsigned DEF_CH_W   = 3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitDone,
        StAccum,
        StPublish
    } vm_state_e;

endpackage

// File: rtl/adc_scan_averager_bank.sv
// Per-channel latest-average bank plus peak-hold bank with combinational reads.
module adc_result_bank #(
    parameter int unsigned NCH    = 8,
    parameter int unsigned CH_W   = 3,
    parameter int unsigned DATA_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_clr_max,
    input  logic [CH_W-1:0]   i_rd_ch,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0] o_rd_max
);

    // Storage spans the full index space so any rd_ch is a legal index.
    localparam int unsigned DEPTH = 1 << CH_W;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DATA_W-1:0] r_max  [DEPTH];
    logic              w_wr_ok;

    assign w_wr_ok = i_we && ({1'b0, i_wr_ch} < (CH_W + 1)'(NCH));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_max[i]  <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_data[i_wr_ch] <= i_wr_data;
            end
            // A clear beats a simultaneous peak update.
            if (i_clr_max) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_max[i] <= '0;
                end
            end else if (w_wr_ok && (i_wr_data > r_max[i_wr_ch])) begin
                r_max[i_wr_ch] <= i_wr_data;
            end
        end
    end

    assign o_rd_data = r_data[i_rd_ch];
    assign o_rd_max  = r_max[i_rd_ch];

endmodule

// File: rtl/adc_scan_averager.sv
// Conversion sequencer and per-channel averager for a START/BUSY/ADDR/DATA ADC
// interface, in single-channel or round-robin scan mode.
module adc_scan_averager
    import voltmeter_pkg::*;
#(
    parameter int unsigned NCH           = 8,
    parameter int unsigned CH_W          = DEF_CH_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned DISCARD_FIRST = 1,
    parameter int unsigned ACK_TIMEOUT   = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mode,
    input  logic [CH_W-1:0]   i_sel_ch,
    output logic [CH_W-1:0]   o_adc_addr,
    output logic              o_adc_start,
    input  logic              i_adc_busy,
    input  logic [DATA_W-1:0] i_adc_data,
    output logic              o_avg_valid,
    output logic [CH_W-1:0]   o_avg_ch,
    output logic [DATA_W-1:0] o_avg_data,
    input  logic [CH_W-1:0]   i_rd_ch,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0] o_rd_max,
    input  logic              i_clr_max,
    output logic              o_ack_err
);

    localparam int unsigned     ACC_W     = DATA_W + AVG_LOG2;
    localparam int unsigned     NS_W      = AVG_LOG2 + 1;
    localparam int unsigned     TO_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [NS_W-1:0] NS_LAST   = NS_W'((1 << AVG_LOG2) - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NCH - 1);
    localparam logic            DISC_INIT = (DISCARD_FIRST != 0);

    vm_state_e         r_state;
    vm_state_e         w_state_next;
    logic              r_mode;
    logic [CH_W-1:0]   r_sel;
    logic [CH_W-1:0]   r_ch;
    logic [ACC_W-1:0]  r_acc;
    logic [NS_W-1:0]   r_nsamp;
    logic [TO_W-1:0]   r_to;
    logic              r_disc;
    logic              r_drop;
    logic              r_ack_err;
    logic [CH_W-1:0]   r_avg_ch;
    logic [DATA_W-1:0] r_avg_data;

    logic [CH_W-1:0]   w_sel;
    logic [CH_W-1:0]   w_ch_step;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_avg;
    logic              w_chg;
    logic              w_in_flight;
    logic              w_capture;
    logic              w_timeout;
    logic              w_keep;
    logic              w_last;
    logic              w_start;
    logic              w_publish;

    assign w_sel       = ({1'b0, i_sel_ch} >= (CH_W + 1)'(NCH)) ? CH_LAST : i_sel_ch;
    assign w_chg       = (i_mode != r_mode) || (!i_mode && (w_sel != r_sel));
    assign w_in_flight = (r_state == StIssue) || (r_state == StWaitAck) ||
                         (r_state == StWaitDone);
    assign w_capture   = (r_state == StWaitDone) && !i_adc_busy;
    assign w_timeout   = (r_state == StWaitAck) && !i_adc_busy && (r_to == TO_LAST);
    assign w_keep      = !w_chg && !r_drop && !r_disc;
    assign w_last      = (r_nsamp == NS_LAST);
    assign w_sum       = r_acc + ACC_W'(i_adc_data);
    assign w_avg       = w_sum[ACC_W-1:AVG_LOG2];
    assign w_ch_step   = (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            StIdle:     w_state_next = StIssue;
            StIssue: begin
                w_start      = 1'b1;
                w_state_next = StWaitAck;
            end
            StWaitAck: begin
                if (i_adc_busy) begin
                    w_state_next = StWaitDone;
                end else if (w_timeout) begin
                    w_state_next = StIssue;
                end
            end
            StWaitDone: begin
                if (!i_adc_busy) begin
                    w_state_next = (w_keep && w_last) ? StPublish : StAccum;
                end
            end
            StAccum:    w_state_next = StIssue;
            StPublish: begin
                w_publish    = 1'b1;
                w_state_next = StIssue;
            end
            default:    w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_mode     <= 1'b0;
            r_sel      <= '0;
            r_ch       <= '0;
            r_acc      <= '0;
            r_nsamp    <= '0;
            r_to       <= '0;
            r_disc     <= DISC_INIT;
            r_drop     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_avg_ch   <= '0;
            r_avg_data <= '0;
        end else begin
            r_mode <= i_mode;
            r_sel  <= w_sel;
            r_to   <= ((r_state == StWaitAck) && !i_adc_busy && !w_timeout) ?
                      r_to + TO_W'(1) : '0;
            if (w_timeout) begin
                r_ack_err <= 1'b1;
            end

            if (w_chg) begin
                // Restart on the new target; a conversion still out on the old
                // address must be thrown away when it lands.
                r_ch    <= i_mode ? '0 : w_sel;
                r_acc   <= '0;
                r_nsamp <= '0;
                r_disc  <= DISC_INIT;
                r_drop  <= w_in_flight && !w_capture && !w_timeout;
            end else if (w_capture) begin
                r_drop <= 1'b0;
                if (r_drop) begin
                    r_drop <= 1'b0;
                end else if (r_disc) begin
                    r_disc <= 1'b0;
                end else if (w_last) begin
                    r_acc      <= '0;
                    r_nsamp    <= '0;
                    r_avg_ch   <= r_ch;
                    r_avg_data <= w_avg;
                    if (r_mode) begin
                        r_ch   <= w_ch_step;
                        r_disc <= DISC_INIT;
                    end
                end else begin
                    r_acc   <= w_sum;
                    r_nsamp <= r_nsamp + NS_W'(1);
                end
            end else if (w_timeout) begin
                r_drop <= 1'b0;
            end
        end
    end

    adc_result_bank #(
        .NCH    (NCH),
        .CH_W   (CH_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_publish),
        .i_wr_ch   (r_avg_ch),
        .i_wr_data (r_avg_data),
        .i_clr_max (i_clr_max),
        .i_rd_ch   (i_rd_ch),
        .o_rd_data (o_rd_data),
        .o_rd_max  (o_rd_max)
    );

    assign o_adc_addr  = r_ch;
    assign o_adc_start = w_start;
    assign o_avg_valid = w_publish;
    assign o_avg_ch    = r_avg_ch;
    assign o_avg_data  = r_avg_data;
    assign o_ack_err   = r_ack_err;

endmodule

// File: tb/tb_adc_scan_averager.sv
// Directed bench for adc_scan_averager: an 8-channel instance for single mode,
// peaks, timeout and reset, and a 4-channel instance free-running in scan mode.
module tb_adc_scan_averager;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  sel_ch = 3'd0;
    logic [2:0]  rd_ch = 3'd0;
    logic        clr_max = 1'b0;
    logic        adc_busy = 1'b0;
    logic [11:0] adc_data = 12'd0;
    logic [2:0]  adc_addr;
    logic        adc_start;
    logic        avg_valid;
    logic [2:0]  avg_ch;
    logic [11:0] avg_data;
    logic [11:0] rd_data;
    logic [11:0] rd_max;
    logic        ack_err;

    adc_scan_averager #(
        .NCH(8), .CH_W(3), .DATA_W(12), .AVG_LOG2(2), .DISCARD_FIRST(1), .ACK_TIMEOUT(15)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel_ch(sel_ch),
        .o_adc_addr(adc_addr), .o_adc_start(adc_start), .i_adc_busy(adc_busy),
        .i_adc_data(adc_data), .o_avg_valid(avg_valid), .o_avg_ch(avg_ch),
        .o_avg_data(avg_data), .i_rd_ch(rd_ch), .o_rd_data(rd_data), .o_rd_max(rd_max),
        .i_clr_max(clr_max), .o_ack_err(ack_err)
    );

    logic        mode4 = 1'b1;
    logic [2:0]  sel4 = 3'd0;
    logic [2:0]  rd4 = 3'd0;
    logic        clr4 = 1'b0;
    logic        busy4 = 1'b0;
    logic [11:0] data4 = 12'd0;
    logic [2:0]  addr4;
    logic        start4;
    logic        v4;
    logic [2:0]  c4;
    logic [11:0] d4;
    logic [11:0] rdd4;
    logic [11:0] rdm4;
    logic        err4;

    adc_scan_averager #(
        .NCH(4), .CH_W(3), .DATA_W(12), .AVG_LOG2(2), .DISCARD_FIRST(1), .ACK_TIMEOUT(15)
    ) dut4 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode4), .i_sel_ch(sel4),
        .o_adc_addr(addr4), .o_adc_start(start4), .i_adc_busy(busy4),
        .i_adc_data(data4), .o_avg_valid(v4), .o_avg_ch(c4),
        .o_avg_data(d4), .i_rd_ch(rd4), .o_rd_data(rdd4), .o_rd_max(rdm4),
        .i_clr_max(clr4), .o_ack_err(err4)
    );

    // ADC model for dut: busy for 3 cycles; data pattern chosen by m_kind.
    int          m_left = 0;
    int          m_kind = 0;
    int          m_cnt = 0;
    int          n2 = 0;
    int          n5 = 0;
    logic        m_noack = 1'b0;
    logic [11:0] m_base = 12'd0;
    logic [2:0]  m_addr = 3'd0;

    always @(negedge clk) begin
        if (!rst) begin
            m_left   = 0;
            adc_busy = 1'b0;
        end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                adc_busy = 1'b0;
                if (m_kind == 0)      adc_data = m_base + 12'(m_cnt);
                else if (m_kind == 1) adc_data = (m_addr == 3'd5) ? 12'(500 + n5) : 12'd200;
                else                  adc_data = m_base;
                m_cnt++;
                if (m_addr == 3'd2) n2++;
                if (m_addr == 3'd5) n5++;
            end
        end else if (adc_start && !m_noack) begin
            adc_busy = 1'b1;
            m_addr   = adc_addr;
            m_left   = 3;
        end
    end

    int          l4 = 0;
    logic [2:0]  a4 = 3'd0;

    always @(negedge clk) begin
        if (!rst) begin
            l4    = 0;
            busy4 = 1'b0;
        end else if (l4 != 0) begin
            l4 = l4 - 1;
            if (l4 == 0) begin
                busy4 = 1'b0;
                data4 = 12'(16 * a4 + 4);
            end
        end else if (start4) begin
            busy4 = 1'b1;
            a4    = addr4;
            l4    = 3;
        end
    end

    int          pub4_n = 0;
    logic [2:0]  pub4_ch [5];
    logic [11:0] pub4_d  [5];
    always @(negedge clk) begin
        if (rst && v4 && pub4_n < 5) begin
            pub4_ch[pub4_n] = c4;
            pub4_d[pub4_n]  = d4;
            pub4_n++;
        end
    end

    int   mon2 = 0;
    logic mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && avg_valid && avg_ch == 3'd2) mon2++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget, output logic ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (adc_start) ok = 1'b1;
        end
    endtask

    task automatic wait_avg(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (avg_valid) ok = 1'b1;
        end
    endtask

    logic ok;
    int   cyc;
    logic prev_busy;

    initial begin
        // Reset, single mode on channel 3, samples 100,101,...
        mode = 1'b0; sel_ch = 3'd3; rd_ch = 3'd3; m_kind = 0; m_base = 12'd100; m_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", 32'(adc_start), 0);
        chk("rst_addr", 32'(adc_addr), 0);
        chk("rst_valid", 32'(avg_valid), 0);
        chk("rst_avg_ch", 32'(avg_ch), 0);
        chk("rst_avg_data", 32'(avg_data), 0);
        chk("rst_ack_err", 32'(ack_err), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_max", 32'(rd_max), 0);
        rst = 1'b1;
        wait_start(10, ok, cyc);
        chk("first_start_seen", 32'(ok), 1);
        chk("first_start_latency", 32'(cyc), 1);
        chk("first_start_addr", 32'(adc_addr), 3);

        wait_avg(200, ok);
        chk("single_avg_seen", 32'(ok), 1);
        chk("single_avg_ch", 32'(avg_ch), 3);
        chk("single_avg_data", 32'(avg_data), 102);
        @(posedge clk);
        #1;
        chk("single_valid_one_cycle", 32'(avg_valid), 0);
        chk("single_rd_data", 32'(rd_data), 102);
        chk("single_rd_max", 32'(rd_max), 102);

        // Channel 2 with 2 accepted samples, then switch to 5.
        m_kind = 1; n2 = 0; n5 = 0; mon2 = 0; mon_en = 1'b1; sel_ch = 3'd2;
        for (int i = 0; i < 200 && n2 < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("ch2_samples_reached", 32'(n2 >= 3), 1);
        sel_ch = 3'd5;
        wait_avg(300, ok);
        chk("switch_avg_seen", 32'(ok), 1);
        chk("switch_avg_ch", 32'(avg_ch), 5);
        chk("switch_avg_data", 32'(avg_data), 502);
        chk("switch_no_ch2_publish", 32'(mon2), 0);
        mon_en = 1'b0;

        // Scan mode on the 4-channel instance.
        for (int i = 0; i < 400 && pub4_n < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("scan_publish_count", 32'(pub4_n), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("scan_ch%0d", i), 32'(pub4_ch[i]), 32'(i % 4));
            chk($sformatf("scan_data%0d", i), 32'(pub4_d[i]), 32'(16 * (i % 4) + 4));
        end

        // Peak hold on channel 1: 500 then 300, then 700 with clr_max.
        m_kind = 2; m_base = 12'd500; sel_ch = 3'd1; rd_ch = 3'd1;
        wait_avg(300, ok);
        chk("peak_avg500_seen", 32'(ok), 1);
        chk("peak_avg500_ch", 32'(avg_ch), 1);
        chk("peak_avg500_data", 32'(avg_data), 500);
        m_base = 12'd300;
        wait_avg(300, ok);
        chk("peak_avg300_data", 32'(avg_data), 300);
        @(posedge clk);
        #1;
        chk("peak_rd_data300", 32'(rd_data), 300);
        chk("peak_rd_max500", 32'(rd_max), 500);
        m_base = 12'd700;
        wait_avg(300, ok);
        chk("peak_avg700_data", 32'(avg_data), 700);
        clr_max = 1'b1;
        m_noack = 1'b1;
        @(posedge clk);
        #1;
        clr_max = 1'b0;
        chk("clr_rd_data700", 32'(rd_data), 700);
        chk("clr_rd_max", 32'(rd_max), 0);
        chk("restart_after_publish", 32'(adc_start), 1);
        chk("pre_timeout_ack_err", 32'(ack_err), 0);
        rd_ch = 3'd3;
        #1;
        chk("clr_other_ch_max", 32'(rd_max), 0);

        // No acknowledge: timeout after 15 WAIT_ACK cycles, reissue same address.
        wait_start(40, ok, cyc);
        chk("timeout_restart_seen", 32'(ok), 1);
        chk("timeout_restart_gap", 32'(cyc), 16);
        chk("timeout_same_addr", 32'(adc_addr), 1);
        chk("timeout_ack_err", 32'(ack_err), 1);
        m_noack = 1'b0;

        // Reset while WAIT_DONE in scan mode.
        mode = 1'b1; rd_ch = 3'd1; prev_busy = 1'b0; ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (adc_busy && prev_busy) ok = 1'b1;
            prev_busy = adc_busy;
        end
        chk("wait_done_reached", 32'(ok), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_start", 32'(adc_start), 0);
        chk("midrst_addr", 32'(adc_addr), 0);
        chk("midrst_valid", 32'(avg_valid), 0);
        chk("midrst_avg_ch", 32'(avg_ch), 0);
        chk("midrst_avg_data", 32'(avg_data), 0);
        chk("midrst_ack_err", 32'(ack_err), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        rst = 1'b1;
        wait_start(10, ok, cyc);
        chk("scan_restart_seen", 32'(ok), 1);
        chk("scan_restart_addr", 32'(adc_addr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
